// File: rtl/ccff_chain_loader.sv
// Configuration-chain sequencer: serialises words onto a CCFF chain head, counting CHAIN_LEN bits,
// with an optional recirculating CRC-8 verify pass through ccff_tail.
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 17,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              verify_en,
  input  logic              abort,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              shift_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned CntW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned RemW = $clog2(WORD_W + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(CHAIN_LEN);
  localparam logic [CntW-1:0] CntLastVerify = CntW'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StVerify, StDone} state_e;

  state_e            state_q;
  logic              verify_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [WORD_W-1:0] shreg_q;
  logic [RemW-1:0]   rem_q;
  logic [7:0]        crc_load_q;
  logic [7:0]        crc_verify_q;
  logic              error_q;
  logic              load_shift;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  always_comb begin
    load_shift = (state_q == StLoad) && (rem_q != '0) && (bit_cnt_q != CntFull);
    // Refill on the cycle the last buffered bit leaves, so words stream without a bubble.
    word_ready = (state_q == StLoad) && (bit_cnt_q != CntFull) &&
                 ((rem_q == '0) || ((rem_q == RemW'(1)) && load_shift));
    shift_en   = load_shift || (state_q == StVerify);
    ccff_head  = (state_q == StVerify) ? ccff_tail : (load_shift & shreg_q[0]);
    busy       = (state_q == StLoad) || (state_q == StVerify);
    done       = (state_q == StDone);
    error      = error_q;
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q      <= StIdle;
      verify_q     <= 1'b0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      rem_q        <= '0;
      crc_load_q   <= '0;
      crc_verify_q <= '0;
      error_q      <= 1'b0;
    end else if (abort) begin
      state_q      <= StIdle;
      verify_q     <= 1'b0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      rem_q        <= '0;
      crc_load_q   <= '0;
      crc_verify_q <= '0;
      error_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q      <= StLoad;
            verify_q     <= verify_en;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            rem_q        <= '0;
            crc_load_q   <= '0;
            crc_verify_q <= '0;
            error_q      <= 1'b0;
          end
        end
        StLoad: begin
          if (bit_cnt_q == CntFull) begin
            // Chain is full: drop leftover bits of the final word and reuse the counter.
            rem_q     <= '0;
            bit_cnt_q <= '0;
            state_q   <= verify_q ? StVerify : StDone;
          end else begin
            if (load_shift) begin
              shreg_q    <= shreg_q >> 1;
              rem_q      <= rem_q - RemW'(1);
              bit_cnt_q  <= bit_cnt_q + CntW'(1);
              crc_load_q <= crc8_step(crc_load_q, shreg_q[0]);
            end
            if (word_valid && word_ready) begin
              shreg_q <= word_data;
              rem_q   <= RemW'(WORD_W);
            end
          end
        end
        StVerify: begin
          crc_verify_q <= crc8_step(crc_verify_q, ccff_tail);
          bit_cnt_q    <= bit_cnt_q + CntW'(1);
          if (bit_cnt_q == CntLastVerify) begin
            error_q <= (crc_load_q != crc8_step(crc_verify_q, ccff_tail));
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
